// File: rtl/btn_pkg.sv
// Shared constants for the push-button debouncer.
// NUM_BTN      : number of button channels on the board.
// DEBOUNCE_DEF : default stable time in clk_25mhz cycles (10 ms at 25 MHz).
// ACT_LOW_DEF  : default polarity mask; set bits are pressed when the raw pin is 0.
package btn_pkg;

  localparam int unsigned NUM_BTN      = 7;
  localparam int unsigned DEBOUNCE_DEF = 250000;
  localparam logic [NUM_BTN-1:0] ACT_LOW_DEF = 7'b0000001;

  // Counter width for a given stable time. The counter only ever holds
  // 0..cycles-1, so clog2 is exactly enough (and at least 1 for cycles >= 2).
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single debounce channel.
// Ports:
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   raw_i     : asynchronous button level, already normalized to 1 = pressed
//   db_o      : debounced level
//   press_o   : one-cycle pulse on db_o 0->1
//   release_o : one-cycle pulse on db_o 1->0
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  // Counter runs only while the synchronized level disagrees with the
  // debounced level; any agreeing cycle clears it, so a bounce restarts the
  // full count. Reaching CNT_MAX commits the new level and clears the count,
  // so the counter can never wrap.
  always_comb begin
    cnt_d   = '0;
    db_d    = db_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d    = s2_q;
        press_d = s2_q;
        rel_d   = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign db_o      = db_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/btn_debounce.sv
// Debouncer for the board push buttons.
// Ports:
//   clk_25mhz   : 25 MHz system clock
//   rst_n       : asynchronous active-low reset
//   btn         : raw asynchronous button pins
//   btn_db      : debounced level per button, 1 = pressed
//   btn_press   : one-cycle pulse when btn_db goes 0->1
//   btn_release : one-cycle pulse when btn_db goes 1->0
// All outputs are registered; there is no combinational path from btn.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned         DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter logic [NUM_BTN-1:0]  ACTIVE_LOW_MASK = ACT_LOW_DEF
) (
  input  logic               clk_25mhz,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  logic [NUM_BTN-1:0] btn_norm;

  // Polarity is fixed before the synchronizer so every channel sees 1 = pressed.
  assign btn_norm = btn ^ ACTIVE_LOW_MASK;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i    (clk_25mhz),
      .rst_ni   (rst_n),
      .raw_i    (btn_norm[g]),
      .db_o     (btn_db[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  logic       clk_25mhz;
  logic       rst_n;
  logic [6:0] btn;
  logic [6:0] btn_db;
  logic [6:0] btn_press;
  logic [6:0] btn_release;

  int n_checks;
  int n_fail;

  logic [6:0] prev_db;
  logic       mon_en;

  btn_debounce #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW_MASK(7'b0000001)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .btn        (btn),
    .btn_db     (btn_db),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_25mhz);
    #1;
  endtask

  // Every cycle: pulses must match a change of btn_db, and press/release
  // are mutually exclusive. Reset clears the level without a pulse.
  always @(negedge clk_25mhz) begin
    if (!rst_n) begin
      prev_db = '0;
    end else if (mon_en) begin
      check("press_vs_db",   {25'd0, btn_press},   {25'd0, btn_db & ~prev_db});
      check("release_vs_db", {25'd0, btn_release}, {25'd0, ~btn_db & prev_db});
      check("press_and_rel", {25'd0, btn_press & btn_release}, 32'd0);
      prev_db = btn_db;
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    prev_db  = '0;
    btn      = 7'b0000001;
    rst_n    = 1'b0;
    #1;
    check("reset_db_async", {25'd0, btn_db}, 32'd0);
    tick(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // btn[0] released (pin high), others low: nothing should ever report.
    tick(10);
    check("idle_db",    {25'd0, btn_db},      32'd0);
    check("idle_press", {25'd0, btn_press},   32'd0);
    check("idle_rel",   {25'd0, btn_release}, 32'd0);

    // Clean press on btn[1]: 2 sync + 4 stable cycles.
    btn[1] = 1'b1;
    tick(5);
    check("b1_db_early", {31'd0, btn_db[1]}, 32'd0);
    tick(1);
    check("b1_db",       {31'd0, btn_db[1]},    32'd1);
    check("b1_press",    {31'd0, btn_press[1]}, 32'd1);
    tick(1);
    check("b1_press_off", {31'd0, btn_press[1]}, 32'd0);
    check("b1_db_hold",   {31'd0, btn_db[1]},    32'd1);

    // Bounce on btn[2]: count restarts from the final rising edge.
    btn[2] = 1'b1;
    tick(3);
    btn[2] = 1'b0;
    tick(1);
    btn[2] = 1'b1;
    tick(5);
    check("b2_db_early", {31'd0, btn_db[2]}, 32'd0);
    tick(1);
    check("b2_db",    {31'd0, btn_db[2]},    32'd1);
    check("b2_press", {31'd0, btn_press[2]}, 32'd1);

    // Active-low btn[0].
    tick(2);
    btn[0] = 1'b0;
    tick(5);
    check("b0_press_early", {31'd0, btn_press[0]}, 32'd0);
    tick(1);
    check("b0_press", {31'd0, btn_press[0]}, 32'd1);
    check("b0_db",    {31'd0, btn_db[0]},    32'd1);
    tick(2);
    btn[0] = 1'b1;
    tick(6);
    check("b0_release", {31'd0, btn_release[0]}, 32'd1);
    check("b0_db_low",  {31'd0, btn_db[0]},      32'd0);

    // Reset mid-count on btn[3]; btn[1], btn[2] stay held through reset.
    tick(2);
    btn[3] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("rst_db",    {25'd0, btn_db},      32'd0);
    check("rst_press", {25'd0, btn_press},   32'd0);
    check("rst_rel",   {25'd0, btn_release}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("post_rst_early", {25'd0, btn_press}, 32'd0);
    tick(1);
    check("post_rst_press", {25'd0, btn_press}, 32'h0E);
    check("post_rst_db",    {25'd0, btn_db},    32'h0E);

    // Simultaneous presses on btn[4] and btn[5], then release btn[4] only.
    tick(2);
    btn[4] = 1'b1;
    btn[5] = 1'b1;
    tick(6);
    check("b45_press", {25'd0, btn_press}, 32'h30);
    tick(2);
    btn[4] = 1'b0;
    tick(6);
    check("b4_release",     {25'd0, btn_release}, 32'h10);
    check("b4_rel_nopress", {25'd0, btn_press},   32'd0);
    check("b4_db",          {25'd0, btn_db},      32'h2E);

    // Random bounce; pulse/level consistency is checked by the monitor.
    for (int i = 0; i < 20000; i++) begin
      for (int b = 0; b < 7; b++)
        if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
      tick(1);
    end

    // Settle to a known level: all released, then everything must clear.
    btn = 7'b0000001;
    tick(10);
    check("final_db", {25'd0, btn_db}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
